// File: rtl/homomorphic_multiply_sequencer.sv
// Sequences ciphertext-1 then ciphertext-2 row reads into the multiplier and counts partial results.
// Optional DRAIN watchdog enabled by defining HM_SEQ_WATCHDOG_EN.
module homomorphic_multiply_sequencer #(
  parameter int DIMENSION        = 1,
  parameter int CIPHERTEXT_WIDTH = 10,
  parameter int TIMEOUT_CYCLES   = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  output logic                        ct1_rd_en,
  output logic [DIMENSION:0]          ct1_rd_addr,
  input  logic [CIPHERTEXT_WIDTH-1:0] ct1_rd_data,
  output logic                        ct2_rd_en,
  output logic [DIMENSION:0]          ct2_rd_addr,
  input  logic [CIPHERTEXT_WIDTH-1:0] ct2_rd_data,
  output logic [CIPHERTEXT_WIDTH-1:0] mul_ct1_entry,
  output logic [CIPHERTEXT_WIDTH-1:0] mul_ct2_entry,
  output logic                        mul_one_en,
  output logic                        mul_two_en,
  output logic [DIMENSION:0]          mul_one_row,
  output logic [DIMENSION:0]          mul_two_row,
  input  logic                        mul_result_en,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic [DIMENSION+1:0]        result_count
);

  localparam int ROW_W = DIMENSION + 1;
  localparam int CNT_W = DIMENSION + 2;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(DIMENSION);
  localparam logic [CNT_W-1:0] FULL     = CNT_W'(DIMENSION + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD1 = 3'd1;
  localparam logic [2:0] S_LOAD2 = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]       state;
  logic [2:0]       state_next;
  logic [ROW_W-1:0] row;
  logic             row_last;
  logic             drain_complete;
  logic             wd_expired;

  assign row_last = (row == LAST_ROW);

  // Completion is seen in the same cycle as the final pulse, so DONE follows the counting edge.
  assign drain_complete = (result_count == FULL) ||
                          (mul_result_en && (result_count == FULL - CNT_W'(1)));

  assign busy          = (state != S_IDLE);
  assign done          = (state == S_DONE);
  assign ct1_rd_en     = (state == S_LOAD1);
  assign ct2_rd_en     = (state == S_LOAD2);
  assign ct1_rd_addr   = ct1_rd_en ? row : '0;
  assign ct2_rd_addr   = ct2_rd_en ? row : '0;
  assign mul_ct1_entry = ct1_rd_data;
  assign mul_ct2_entry = ct2_rd_data;

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_LOAD1;
      S_LOAD1: if (row_last) state_next = S_LOAD2;
      S_LOAD2: if (row_last) state_next = S_DRAIN;
      S_DRAIN: if (drain_complete || wd_expired) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= '0;
    end else if ((state == S_LOAD1) || (state == S_LOAD2)) begin
      row <= row_last ? '0 : row + ROW_W'(1);
    end else begin
      row <= '0;
    end
  end

  // Multiplier strobes trail the read strobes by one cycle to line up with read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_one_en  <= 1'b0;
      mul_two_en  <= 1'b0;
      mul_one_row <= '0;
      mul_two_row <= '0;
    end else begin
      mul_one_en  <= ct1_rd_en;
      mul_two_en  <= ct2_rd_en;
      mul_one_row <= ct1_rd_addr;
      mul_two_row <= ct2_rd_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_count <= '0;
    end else if (state == S_IDLE) begin
      if (start) result_count <= '0;
    end else if (mul_result_en && (result_count != FULL)) begin
      result_count <= result_count + CNT_W'(1);
    end
  end

`ifdef HM_SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_cnt;

  assign wd_expired = (state == S_DRAIN) && !drain_complete && (wd_cnt == WD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 wd_cnt <= '0;
    else if (state == S_DRAIN)  wd_cnt <= wd_cnt + WD_W'(1);
    else                        wd_cnt <= '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          err <= 1'b0;
    else if ((state == S_IDLE) && start) err <= 1'b0;
    else if (wd_expired)                 err <= 1'b1;
  end
`else
  assign wd_expired = 1'b0;
  assign err        = 1'b0;

  // Keeps TIMEOUT_CYCLES referenced when the watchdog is compiled out.
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
  end
`endif

endmodule
